param_sample_fifo: RTL
======================

Name: param_sample_fifo

Overview:
- Single-clock, parametrised sample FIFO with show-ahead output, registered occupancy flags, overflow/underflow accounting and synchronous flush.
- Successor to the fixed 16-bit/8192-word buffer: width, depth and flag thresholds are generic.
- Sits between the ADC sample capture and the USB transfer interface, in the sampling clock domain. It gives the transfer state machine exact fill level and data-loss statistics.

Parameters:
DATA_WIDTH, 16, width of each stored sample word.
ADDR_WIDTH, 13, log2 of depth; DEPTH = 2**ADDR_WIDTH words.
ALMOST_EMPTY_LEVEL, 8, almostEmpty_flag is asserted while level < this value.
HALF_FULL_LEVEL, 4096, halfFull_flag is asserted while level > this value.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of contents; statistics are kept.
inputData  in  DATA_WIDTH  sample to write.
inputValid  in  1  write request for inputData this cycle.
outputData  out  DATA_WIDTH  head-of-FIFO word (show-ahead).
outputAck  in  1  consume head word this cycle.
level  out  ADDR_WIDTH+1  words currently stored, 0..DEPTH.
empty_flag  out  1  level == 0.
almostEmpty_flag  out  1  level < ALMOST_EMPTY_LEVEL.
halfFull_flag  out  1  level > HALF_FULL_LEVEL.
full_flag  out  1  level == DEPTH.
overflow_flag  out  1  sticky: at least one write was dropped.
underflow_flag  out  1  sticky: outputAck was received while empty.
droppedCount  out  16  dropped writes, saturating.

Behaviour:
- Reset (synchronous, top priority):
  - Pointers and level are 0.
  - empty_flag=1, almostEmpty_flag=1, halfFull_flag=0, full_flag=0.
  - overflow_flag=0, underflow_flag=0, droppedCount=0, outputData=0.
- Flush (second priority):
  - Same as reset for pointers, level and the four occupancy flags.
  - overflow_flag, underflow_flag and droppedCount hold their values.
  - A write in the flush cycle is discarded and not counted as dropped.
- Write acceptance: a word is accepted when inputValid=1 and (level < DEPTH, or outputAck=1 with level == DEPTH).
  - A read on a full FIFO frees a slot in the same cycle.
- Read: on a cycle with outputAck=1 and level > 0, the head word is consumed.
  - The next word appears on outputData at the following edge.
- Show-ahead timing:
  - outputData always presents the oldest stored word whenever level > 0.
  - A word written into an empty FIFO at edge N is on outputData and level=1 after edge N.
  - outputData is undefined-but-stable (last value held) while empty.
- Simultaneous read and write:
  - Level unchanged when both succeed.
  - On an empty FIFO, outputAck is treated as an underflow. The write still succeeds, so level becomes 1 and underflow_flag is set.
- Dropped write: inputValid=1 with level == DEPTH and outputAck=0.
  - Data is discarded.
  - overflow_flag is set.
  - droppedCount increments, saturating at 16'hFFFF (no wrap).
- Underflow: outputAck=1 while level == 0. No pointer change; underflow_flag is set.
- Flag timing:
  - All four occupancy flags are registered from the next-level value, so they are consistent with level on every cycle (zero lag).
  - Thresholds use strict comparison exactly as listed under Ports.
- Pointer arithmetic:
  - Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
  - level is ADDR_WIDTH+1 bits so DEPTH is representable.
- Storage is inferred block RAM. A registered head/bypass stage provides show-ahead with no added latency beyond what is defined above.

Test Plan:
- Reset, then write 3 words 0x0001..0x0003 on consecutive cycles with no ack.
  -> level=3; outputData=0x0001 one edge after the first write; empty_flag deasserts with the first write; almostEmpty_flag=1.
- Write DEPTH words (8192), then one extra write.
  -> full_flag=1; level=8192; overflow_flag=1; droppedCount=1. The extra word never appears on read-back.
- From full, assert inputValid and outputAck together for 10 cycles with incrementing data.
  -> level stays 8192; droppedCount unchanged; output sequence is contiguous with no gaps.
- Fill to 4097 words, then ack once.
  -> halfFull_flag=1 at 4097 and 0 at 4096. Draining to 7 words -> almostEmpty_flag=1 at 7 and 0 at 8.
- Force 70000 dropped writes, then pulse flush.
  -> droppedCount saturates at 0xFFFF. After flush: level=0, empty_flag=1, overflow_flag=1, droppedCount=0xFFFF. reset clears both.
- On an empty FIFO, assert outputAck together with a write of 0xABCD.
  -> underflow_flag=1; level=1; outputData=0xABCD after the edge. Data is read back correctly on the next ack.

Source files
------------

// File: rtl/param_sample_fifo.sv
// Single-clock show-ahead sample FIFO between ADC capture and USB transfer.
// Tracks exact fill level, occupancy thresholds and data-loss statistics.
module param_sample_fifo #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 13,
  parameter int ALMOST_EMPTY_LEVEL = 8,
  parameter int HALF_FULL_LEVEL    = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] inputData,
  input  logic                  inputValid,
  output logic [DATA_WIDTH-1:0] outputData,
  input  logic                  outputAck,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty_flag,
  output logic                  almostEmpty_flag,
  output logic                  halfFull_flag,
  output logic                  full_flag,
  output logic                  overflow_flag,
  output logic                  underflow_flag,
  output logic [15:0]           droppedCount
);

  localparam int LW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AE_L    = LW'(ALMOST_EMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] HF_L    = LW'(HALF_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_L   = LW'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] head_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  empty_q, aempty_q, hfull_q, full_q;
  logic                  ovf_q, unf_q;
  logic [15:0]           drop_cnt_q;
  logic                  is_empty, is_full;
  logic                  wr_en, rd_en, drop, under, bypass;

  always_comb begin
    is_empty = (level_q == '0);
    is_full  = (level_q == DEPTH_L);
    // A read on a full FIFO frees the slot the concurrent write lands in.
    rd_en    = !flush && outputAck && !is_empty;
    wr_en    = !flush && inputValid && (!is_full || outputAck);
    drop     = !flush && inputValid && is_full && !outputAck;
    under    = !flush && outputAck && is_empty;
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_en);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_en);
    level_d  = level_q;
    if (wr_en && !rd_en)      level_d = level_q + ONE_L;
    else if (rd_en && !wr_en) level_d = level_q - ONE_L;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    // New word becomes head directly when nothing older survives this edge.
    bypass = wr_en && (is_empty || (rd_en && (level_q == ONE_L)));
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= inputData;
  end

  always_ff @(posedge clock) begin
    if (reset)       head_q <= '0;
    else if (bypass) head_q <= inputData;
    else if (rd_en)  head_q <= mem_q[rd_ptr_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
      hfull_q    <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= (level_d == '0);
      aempty_q   <= (level_d < AE_L);
      hfull_q    <= (level_d > HF_L);
      full_q     <= (level_d == DEPTH_L);
      ovf_q      <= ovf_q | drop;
      unf_q      <= unf_q | under;
      drop_cnt_q <= sat_inc16(drop_cnt_q, drop);
    end
  end

  assign outputData       = head_q;
  assign level            = level_q;
  assign empty_flag       = empty_q;
  assign almostEmpty_flag = aempty_q;
  assign halfFull_flag    = hfull_q;
  assign full_flag        = full_q;
  assign overflow_flag    = ovf_q;
  assign underflow_flag   = unf_q;
  assign droppedCount     = drop_cnt_q;

endmodule
